nios2_debug_ocimem_ctrl: RTL
============================

Name: nios2_debug_ocimem_ctrl

Overview:
- Consumes the sysclk-domain debug command strobes and jdo word from the debug slave and executes them against the 256x32 on-chip debug RAM.
- Returns read data and monitor status (MonDReg, monitor_ready, monitor_error) to the debug slave.
- Arbitrates the same RAM against the CPU-side Avalon debug port, which also exposes the monitor control register.

Parameters:
ADDR_W, 8, RAM word-address width; RAM depth is 2**ADDR_W.
DATA_W, 32, data width; fixed at 32 to match MonDReg and jdo fields.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
jdo  in  38  command data from the debug slave
take_action_ocimem_a  in  1  address/control command strobe
take_action_ocimem_b  in  1  write-data command strobe
take_no_action_ocimem_a  in  1  read-next command strobe
MonDReg  out  32  last JTAG read/write data
monitor_ready  out  1  monitor status flag
monitor_error  out  1  monitor status flag
monitor_go  out  1  go request to the monitor
avs_address  in  ADDR_W+1  bit ADDR_W: 0=RAM, 1=control register
avs_read  in  1  Avalon read
avs_write  in  1  Avalon write
avs_writedata  in  32  Avalon write data
avs_byteenable  in  4  Avalon byte enables
avs_readdata  out  32  Avalon read data
avs_waitrequest  out  1  Avalon waitrequest
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  32  RAM write data
ram_be  out  4  RAM byte enables
ram_we  out  1  RAM write enable
ram_re  out  1  RAM read enable
ram_rdata  in  32  RAM read data; 1-cycle latency after ram_re

Behaviour:
Reset:
- All outputs 0 except avs_waitrequest=1.
- Internal address register MonAReg=0; pending command cleared; FSM to IDLE.
- Reset mid-transaction abandons the transaction; no RAM write completes after reset.

Command capture:
- A strobe is registered into a one-entry pending slot in the cycle it is seen.
- Simultaneous strobes: priority ocimem_b > ocimem_a > no_action_ocimem_a; the others are dropped.
- A new strobe while a command is pending overwrites it.

Command semantics:
- ocimem_a: MonAReg<=jdo[33:26].
  - jdo[23]=1 sets monitor_go.
  - jdo[22]=1 clears monitor_ready and monitor_error.
  - jdo[17]=1 additionally performs a read at the new address.
- ocimem_b: writes jdo[34:3] to mem[MonAReg] with all byte enables set; MonDReg<=jdo[34:3]; MonAReg increments.
- no_action_ocimem_a: reads mem[MonAReg] into MonDReg; MonAReg increments.
- Increment wraps 2**ADDR_W-1 -> 0.

FSM states: IDLE, J_ACC, J_CAP, C_ACC, C_CAP.
- IDLE:
  - Pending JTAG command: go to J_ACC. JTAG has priority over the CPU.
  - Else avs_read/avs_write: go to C_ACC.
- J_ACC: drives ram_re or ram_we at MonAReg; a control-only ocimem_a skips RAM access. Next state J_CAP for reads, IDLE otherwise.
- J_CAP: MonDReg<=ram_rdata; MonAReg increments; next state IDLE.
- JTAG latency with the FSM idle: strobe in cycle T -> RAM access in T+1 -> MonDReg valid in T+3.
- C_ACC:
  - RAM write: ram_we with avs_byteenable; avs_waitrequest=0 this cycle; next state IDLE.
  - RAM read: ram_re; next state C_CAP.
  - Control register: completes in C_ACC with avs_waitrequest=0; next state IDLE.
- C_CAP: avs_readdata<=ram_rdata; avs_waitrequest=0; next state IDLE.
- A CPU request arriving while a JTAG command runs holds with avs_waitrequest=1.
- A JTAG strobe arriving during a CPU transaction waits in the pending slot until IDLE.

Control register (avs_address[ADDR_W]=1):
- Read returns {29'b0, monitor_go, monitor_error, monitor_ready}.
- Write:
  - bit0=1 sets monitor_ready.
  - monitor_error<=bit1.
  - bit2=1 clears monitor_go.
- A JTAG set of monitor_go and a CPU clear in the same cycle: JTAG wins.

avs_waitrequest is 1 in every cycle except the completion cycle of a CPU transaction.

Decomposition:
- Shared package holds:
  - FSM state enum.
  - Pending-command type: NONE/ADDR/WRITE/READNEXT.
  - jdo field positions: ADDR 33:26, WDATA 34:3, GO 23, CLR 22, RD 17.
  - Control-register bit indices.
- No sub-module; the RAM remains outside this block.

Test Plan:
1. ocimem_a with jdo[33:26]=0x10, jdo[17]=1, mem[0x10]=0xDEADBEEF -> MonDReg=0xDEADBEEF three cycles after the strobe; MonAReg=0x11.
2. ocimem_b with jdo[34:3]=0x12345678 at MonAReg=0xFF -> ram_we at address 0xFF with ram_be=0xF; MonAReg wraps to 0x00; a following no_action read returns mem[0x00].
3. avs_read asserted in the same cycle as a take_action_ocimem_b strobe -> JTAG write completes first; the CPU read completes with waitrequest low 2 cycles later and returns the newly written data.
4. ocimem_a with jdo[23]=1 -> monitor_go=1; CPU writes 0x5 to the control register -> monitor_ready=1, monitor_go=0; a control read returns 0x1.
5. take_action_ocimem_a and take_action_ocimem_b strobed in the same cycle -> only the write executes; MonAReg is unchanged by the address command.
6. reset asserted in C_CAP -> next cycle avs_waitrequest=1, MonDReg=0, all monitor flags 0, no ram_we.

Source files
------------

// File: rtl/nios2_debug_ocimem_ctrl_pkg.sv
// Shared types and field positions for the OCI debug-memory controller.
package nios2_debug_ocimem_ctrl_pkg;

  // Controller FSM: JTAG access/capture and CPU access/capture.
  typedef enum logic [2:0] {
    IDLE,
    J_ACC,
    J_CAP,
    C_ACC,
    C_CAP
  } state_t;

  // Kind of JTAG command held in the one-entry pending slot.
  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_ADDR,
    CMD_WRITE,
    CMD_READNEXT
  } cmd_t;

  // jdo field positions
  localparam int JDO_W        = 38;
  localparam int JDO_ADDR_HI  = 33;
  localparam int JDO_ADDR_LO  = 26;
  localparam int JDO_WDATA_HI = 34;
  localparam int JDO_WDATA_LO = 3;
  localparam int JDO_GO       = 23;
  localparam int JDO_CLR      = 22;
  localparam int JDO_RD       = 17;

  // Monitor control register bit indices
  localparam int CTRL_READY = 0;
  localparam int CTRL_ERROR = 1;
  localparam int CTRL_GO    = 2;

  // Pending JTAG command: only the jdo fields the command needs are kept.
  typedef struct packed {
    cmd_t        cmd;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        go;
    logic        clr;
    logic        rd;
  } pend_t;

endpackage

// File: rtl/nios2_debug_ocimem_ctrl.sv
// OCI debug-memory controller: executes JTAG debug commands against the
// debug RAM and arbitrates that RAM with the CPU-side Avalon debug port,
// which also exposes the monitor control register.
module nios2_debug_ocimem_ctrl
  import nios2_debug_ocimem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [JDO_W-1:0]      jdo,
  input  logic                  take_action_ocimem_a,
  input  logic                  take_action_ocimem_b,
  input  logic                  take_no_action_ocimem_a,
  output logic [DATA_W-1:0]     MonDReg,
  output logic                  monitor_ready,
  output logic                  monitor_error,
  output logic                  monitor_go,
  input  logic [ADDR_W:0]       avs_address,
  input  logic                  avs_read,
  input  logic                  avs_write,
  input  logic [DATA_W-1:0]     avs_writedata,
  input  logic [DATA_W/8-1:0]   avs_byteenable,
  output logic [DATA_W-1:0]     avs_readdata,
  output logic                  avs_waitrequest,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic [DATA_W/8-1:0]   ram_be,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [DATA_W-1:0]     ram_rdata
);

  state_t            state, state_nxt;
  cmd_t              in_cmd;
  pend_t             pend;
  logic [ADDR_W-1:0] mon_a;
  logic [ADDR_W-1:0] j_addr;
  logic              jtag_req;
  logic              j_rd;
  logic              cpu_ctrl;
  logic              cpu_req;
  logic [DATA_W-1:0] ctrl_rd;
  logic              unused_jdo;

  // jdo bits outside every command field carry nothing for this block
  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  assign jtag_req = (in_cmd != CMD_NONE) || (pend.cmd != CMD_NONE);
  assign j_rd     = (pend.cmd == CMD_READNEXT) || ((pend.cmd == CMD_ADDR) && pend.rd);
  // An address command with read accesses the new address, not the old one
  assign j_addr   = (pend.cmd == CMD_ADDR) ? pend.addr[ADDR_W-1:0] : mon_a;
  assign cpu_ctrl = avs_address[ADDR_W];
  assign cpu_req  = avs_read | avs_write;
  assign ctrl_rd  = {{(DATA_W-3){1'b0}}, monitor_go, monitor_error, monitor_ready};

  // Strobe priority: write > address > read-next; the others are dropped
  always_comb begin
    in_cmd = CMD_NONE;
    if (take_action_ocimem_b)         in_cmd = CMD_WRITE;
    else if (take_action_ocimem_a)    in_cmd = CMD_ADDR;
    else if (take_no_action_ocimem_a) in_cmd = CMD_READNEXT;
  end

  // Pending slot: a new strobe overwrites; J_ACC consumes the held command
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else if (in_cmd != CMD_NONE) begin
      pend.cmd   <= in_cmd;
      pend.addr  <= jdo[JDO_ADDR_HI:JDO_ADDR_LO];
      pend.wdata <= jdo[JDO_WDATA_HI:JDO_WDATA_LO];
      pend.go    <= jdo[JDO_GO];
      pend.clr   <= jdo[JDO_CLR];
      pend.rd    <= jdo[JDO_RD];
    end else if (state == J_ACC) begin
      pend.cmd <= CMD_NONE;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: a strobe seen in IDLE starts J_ACC the very next cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (jtag_req)     state_nxt = J_ACC;
               else if (cpu_req) state_nxt = C_ACC;
      J_ACC:   state_nxt = j_rd ? J_CAP : IDLE;
      J_CAP:   state_nxt = IDLE;
      C_ACC:   state_nxt = (!cpu_ctrl && avs_read && !avs_write) ? C_CAP : IDLE;
      C_CAP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port and Avalon response driven from the current state
  always_comb begin
    ram_addr        = '0;
    ram_wdata       = '0;
    ram_be          = '0;
    ram_we          = 1'b0;
    ram_re          = 1'b0;
    avs_waitrequest = 1'b1;
    avs_readdata    = '0;
    case (state)
      J_ACC: begin
        ram_addr = j_addr;
        if (pend.cmd == CMD_WRITE) begin
          ram_we    = 1'b1;
          ram_be    = '1;
          ram_wdata = pend.wdata;
        end else if (j_rd) begin
          ram_re = 1'b1;
        end
      end
      C_ACC: begin
        if (cpu_ctrl) begin
          avs_waitrequest = !cpu_req;
          avs_readdata    = ctrl_rd;
        end else if (avs_write) begin
          ram_addr        = avs_address[ADDR_W-1:0];
          ram_we          = 1'b1;
          ram_be          = avs_byteenable;
          ram_wdata       = avs_writedata;
          avs_waitrequest = 1'b0;
        end else if (avs_read) begin
          ram_addr = avs_address[ADDR_W-1:0];
          ram_re   = 1'b1;
        end
      end
      C_CAP: begin
        avs_readdata    = ram_rdata;
        avs_waitrequest = 1'b0;
      end
      default: ;
    endcase
  end

  // Address register, JTAG data register and monitor flags.
  // The FSM never sits in J_ACC and C_ACC at once, so a JTAG go-set and a
  // CPU go-clear cannot collide; the JTAG update is still ordered last.
  always_ff @(posedge clk) begin
    if (reset) begin
      mon_a         <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      monitor_go    <= 1'b0;
    end else begin
      if (state == C_ACC && cpu_ctrl && avs_write) begin
        if (avs_writedata[CTRL_READY]) monitor_ready <= 1'b1;
        monitor_error <= avs_writedata[CTRL_ERROR];
        if (avs_writedata[CTRL_GO]) monitor_go <= 1'b0;
      end
      case (state)
        J_ACC: begin
          case (pend.cmd)
            CMD_ADDR: begin
              mon_a <= pend.addr[ADDR_W-1:0];
              if (pend.go) monitor_go <= 1'b1;
              if (pend.clr) begin
                monitor_ready <= 1'b0;
                monitor_error <= 1'b0;
              end
            end
            CMD_WRITE: begin
              MonDReg <= pend.wdata;
              mon_a   <= mon_a + ADDR_W'(1);
            end
            default: ;
          endcase
        end
        J_CAP: begin
          MonDReg <= ram_rdata;
          mon_a   <= mon_a + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
